// File: rtl/alsu_cmd_issuer.sv
// alsu_cmd_issuer: command FIFO and issue stage in front of the ALSU.
// Commands are queued, popped one per cycle unless held, and presented
// to the ALSU from registers. A {valid, tag} shift pipeline of LATENCY
// stages marks the cycle in which the ALSU output of each command appears.
// Optional feature macro: ALSU_ISSUER_ILLEGAL_FILTER_EN drops illegal
// opcode combinations at the FIFO input and counts them in drop_cnt.
module alsu_cmd_issuer #(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [15:0]       cmd_data,
   input  logic              hold,
   output logic signed [2:0] A,
   output logic signed [2:0] B,
   output logic              cin,
   output logic              serial_in,
   output logic              red_op_A,
   output logic              red_op_B,
   output logic [2:0]        opcode,
   output logic              bypass_A,
   output logic              bypass_B,
   output logic              direction,
   output logic              issue_vld,
   output logic              res_valid,
   output logic [3:0]        res_tag,
   output logic [7:0]        drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          accept, illegal, push, pop;

   logic [15:0]   issue_cmd;
   logic [3:0]    tag, issue_tag;
   logic [LATENCY-1:0]      vld_pipe;
   logic [LATENCY-1:0][3:0] tag_pipe;

   // Ready depends on occupancy only; a pop in the same cycle does not free a slot early.
   assign cmd_ready = (count != CW'(DEPTH));
   assign accept    = cmd_valid && cmd_ready;

`ifdef ALSU_ISSUER_ILLEGAL_FILTER_EN
   // Opcodes 6/7, and reduction with anything other than OR/XOR, are rejected.
   assign illegal = (cmd_data[5:3] > 3'd5) ||
                    ((cmd_data[7] || cmd_data[6]) && (cmd_data[5:3] > 3'd1));
`else
   assign illegal = 1'b0;
`endif

   assign push = accept && !illegal;
   assign pop  = (count != '0) && !hold;

   // FIFO storage write
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cmd_data;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Issue registers: load the head on a pop, otherwise present a NOP.
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cmd <= '0;
         issue_vld <= 1'b0;
         issue_tag <= '0;
         tag       <= '0;
      end else begin
         issue_vld <= pop;
         if (pop) begin
            issue_cmd <= mem[rd_ptr];
            issue_tag <= tag;
            tag       <= tag + 4'd1;
         end else begin
            issue_cmd <= '0;
            issue_tag <= '0;
         end
      end
   end

   assign A         = issue_cmd[15:13];
   assign B         = issue_cmd[12:10];
   assign cin       = issue_cmd[9];
   assign serial_in = issue_cmd[8];
   assign red_op_A  = issue_cmd[7];
   assign red_op_B  = issue_cmd[6];
   assign opcode    = issue_cmd[5:3];
   assign bypass_A  = issue_cmd[2];
   assign bypass_B  = issue_cmd[1];
   assign direction = issue_cmd[0];

   // Result pipeline: delays {issue_vld, tag} to line up with the ALSU output.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else begin
         vld_pipe[0] <= issue_vld;
         tag_pipe[0] <= issue_tag;
         for (int i = 1; i < LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   assign res_valid = vld_pipe[LATENCY-1];
   assign res_tag   = tag_pipe[LATENCY-1];

`ifdef ALSU_ISSUER_ILLEGAL_FILTER_EN
   // Count accepted-but-dropped commands, saturating.
   always_ff @(posedge clk) begin
      if (rst)                                   drop_cnt <= '0;
      else if (accept && illegal && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
   end
`else
   assign drop_cnt = '0;
`endif

endmodule
